// File: rtl/bat_pkg.sv
// Shared constants for the bat register file slice.
// Register indices and default word width.
package bat_pkg;

    localparam int REG_A    = 0;
    localparam int REG_B    = 1;
    localparam int REG_OUT  = 7;
    localparam int NUM_REGS = 8;
    localparam int WORD_W   = 8;

endpackage

// File: rtl/bat_out_fifo.sv
// Output FIFO fed by updates of the OUT register.
// Registered level, wrapping pointers, sticky overflow.
module bat_out_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty,
    output logic                     o_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             r_overflow;

    logic w_pop;
    logic w_push_ok;
    logic w_drop;

    assign o_empty    = (r_level == '0);
    assign o_full     = (r_level == LW'(DEPTH));
    assign w_pop      = i_pop & ~o_empty;
    assign w_push_ok  = i_push & (~o_full | w_pop);
    assign w_drop     = i_push & o_full & ~w_pop;
    assign o_data     = o_empty ? '0 : r_mem[r_rd_ptr];
    assign o_level    = r_level;
    assign o_overflow = r_overflow;

    // Storage write; contents need no reset since pointers gate visibility.
    always_ff @(posedge CLK) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers, occupancy and sticky overflow flag.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push_ok && !w_pop) begin
                r_level <= r_level + LW'(1);
            end else if (!w_push_ok && w_pop) begin
                r_level <= r_level - LW'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/bat_register_file.sv
// General register file driven by per-register strobes.
// Lowest-index reader owns the bus; OUT updates feed a FIFO.
module bat_register_file
    import bat_pkg::*;
#(
    parameter int WIDTH     = WORD_W,
    parameter int OUT_DEPTH = 4,
    parameter int OUT_IDX   = REG_OUT
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [NUM_REGS-1:0]         REGS_INC,
    input  logic [NUM_REGS-1:0]         REGS_RW,
    input  logic [NUM_REGS-1:0]         REGS_EN,
    input  logic [WIDTH-1:0]            BUS_IN,
    output logic [WIDTH-1:0]            BUS_OUT,
    output logic                        BUS_OE,
    output logic [WIDTH-1:0]            ALU_A,
    output logic [WIDTH-1:0]            ALU_B,
    output logic [WIDTH-1:0]            OUT_DATA,
    output logic                        OUT_VALID,
    input  logic                        OUT_READY,
    output logic [$clog2(OUT_DEPTH):0]  OUT_LEVEL,
    output logic                        ERR_CONFLICT,
    output logic                        ERR_OVERFLOW
);

    logic [WIDTH-1:0]    r_regs [NUM_REGS];
    logic                r_err_conflict;

    logic [NUM_REGS-1:0] w_rd;
    logic [NUM_REGS-1:0] w_wr;
    logic                w_conflict;
    logic [WIDTH-1:0]    w_bus;
    logic                w_push;
    logic [WIDTH-1:0]    w_out_next;
    logic                w_full;
    logic                w_empty;

    assign w_rd       = REGS_EN & REGS_RW;
    assign w_wr       = REGS_EN & ~REGS_RW;
    assign w_conflict = |(w_rd & (w_rd - NUM_REGS'(1)));

    // Read mux: scan downward so the lowest-index reader ends up on the bus.
    always_comb begin
        w_bus = '0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (w_rd[i]) begin
                w_bus = r_regs[i];
            end
        end
    end

    assign BUS_OUT = w_bus;
    assign BUS_OE  = |w_rd;
    assign ALU_A   = r_regs[REG_A];
    assign ALU_B   = r_regs[REG_B];

    // Value OUT will hold after this edge; write beats increment.
    assign w_push     = w_wr[OUT_IDX] | REGS_INC[OUT_IDX];
    assign w_out_next = w_wr[OUT_IDX] ? BUS_IN
                                      : r_regs[OUT_IDX] + WIDTH'(1);

    // Register array update: write has priority, increment wraps.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_wr[i]) begin
                    r_regs[i] <= BUS_IN;
                end else if (REGS_INC[i]) begin
                    r_regs[i] <= r_regs[i] + WIDTH'(1);
                end
            end
        end
    end

    // Sticky read-conflict flag.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_err_conflict <= 1'b0;
        end else if (w_conflict) begin
            r_err_conflict <= 1'b1;
        end
    end

    assign ERR_CONFLICT = r_err_conflict;

    bat_out_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .CLK         (CLK),
        .RST         (RST),
        .i_push      (w_push),
        .i_push_data (w_out_next),
        .i_pop       (OUT_READY),
        .o_data      (OUT_DATA),
        .o_level     (OUT_LEVEL),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_overflow  (ERR_OVERFLOW)
    );

    assign OUT_VALID = ~w_empty;

endmodule
